// File: rtl/ni_defines.sv
// Shared flit encodings, header field offsets and NI FSM states.
// Used by the transmit packetizer and its output register.
package ni_defines;

  localparam logic [2:0] FLIT_HEADER = 3'b001;
  localparam logic [2:0] FLIT_BODY   = 3'b010;
  localparam logic [2:0] FLIT_TAIL   = 3'b100;

  localparam int FLIT_ID_LSB = 29;
  localparam int LEN_LSB     = 17;
  localparam int DST_LSB     = 13;
  localparam int SRC_LSB     = 9;

  typedef enum logic [1:0] {
    NI_IDLE    = 2'd0,
    NI_PAYLOAD = 2'd1,
    NI_DRAIN   = 2'd2
  } ni_state_t;

  function automatic logic [31:0] make_header(
    input logic [11:0] len,
    input logic [3:0]  dst,
    input logic [3:0]  src,
    input logic [8:0]  seq
  );
    logic [31:0] h;
    h = '0;
    h[FLIT_ID_LSB +: 3] = FLIT_HEADER;
    h[LEN_LSB +: 12]    = len + 12'd1;
    h[DST_LSB +: 4]     = dst;
    h[SRC_LSB +: 4]     = src;
    h[8:0]              = seq;
    return h;
  endfunction

endpackage

// File: rtl/ni_out_reg.sv
// Valid/ready output register: loads when empty or draining,
// holds data and valid while the sink stalls.
module ni_out_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic             ready_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             ld_ok
);

  assign ld_ok = !valid_out || ready_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (ld) begin
      data_out  <= din;
      valid_out <= 1'b1;
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: rtl/ni_packetizer.sv
// NI transmit side: message request + payload words -> header/body/tail flits.
// Define NI_PKT_SEQ_EN to stamp a 9-bit message sequence into header [8:0].
module ni_packetizer
  import ni_defines::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PL_WIDTH   = 29,
  parameter int MAX_LEN    = 4094
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            cur_addr,
  input  logic                  msg_valid,
  output logic                  msg_ready,
  input  logic [3:0]            msg_dst,
  input  logic [11:0]           msg_len,
  input  logic                  pl_valid,
  output logic                  pl_ready,
  input  logic [PL_WIDTH-1:0]   pl_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  busy,
  output logic                  len_err
);

  ni_state_t state, state_nx;
  logic [11:0] cnt;
  logic [8:0]  hdr_seq;
  logic        live;
  logic        ld_ok;
  logic        ld;
  logic [DATA_WIDTH-1:0] din;
  logic        len_ok;
  logic        msg_fire;
  logic        pl_fire;
  logic        accept;
  logic        reject;
  logic        last;

  assign len_ok   = (msg_len != 12'd0) && (msg_len <= 12'(MAX_LEN));
  assign msg_fire = msg_valid && msg_ready;
  assign pl_fire  = pl_valid && pl_ready;
  assign accept   = msg_fire && len_ok;
  assign reject   = msg_fire && !len_ok;
  assign last     = (cnt == 12'd1);
  assign busy     = (state != NI_IDLE);

`ifdef NI_PKT_SEQ_EN
  logic [8:0] seq;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq <= '0;
    end else if (accept) begin
      seq <= seq + 9'd1;
    end
  end

  assign hdr_seq = seq;
`else
  assign hdr_seq = 9'd0;
`endif

  // live holds msg_ready low for the first cycle out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= NI_IDLE;
      cnt     <= '0;
      live    <= 1'b0;
      len_err <= 1'b0;
    end else begin
      state   <= state_nx;
      live    <= 1'b1;
      len_err <= reject;
      if (accept) begin
        cnt <= msg_len;
      end else if (pl_fire) begin
        cnt <= cnt - 12'd1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      NI_IDLE:    if (accept) state_nx = NI_PAYLOAD;
      NI_PAYLOAD: if (pl_fire && last) state_nx = NI_DRAIN;
      NI_DRAIN:   if (valid_out && ready_in) state_nx = NI_IDLE;
      default:    state_nx = NI_IDLE;
    endcase
  end

  always_comb begin
    msg_ready = 1'b0;
    pl_ready  = 1'b0;
    ld        = 1'b0;
    din       = '0;
    unique case (state)
      NI_IDLE: begin
        msg_ready = ld_ok && live;
        ld        = accept;
        din       = make_header(msg_len, msg_dst, cur_addr, hdr_seq);
      end
      NI_PAYLOAD: begin
        pl_ready = ld_ok;
        ld       = pl_fire;
        din      = {(last ? FLIT_TAIL : FLIT_BODY), pl_data};
      end
      default: begin
        msg_ready = 1'b0;
      end
    endcase
  end

  ni_out_reg #(
    .WIDTH(DATA_WIDTH)
  ) u_out (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld),
    .din      (din),
    .ready_in (ready_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .ld_ok    (ld_ok)
  );

endmodule

// File: tb/tb_ni_packetizer.sv
// Scoreboard bench for ni_packetizer: flits expected at handshake,
// compared on transfer.
module tb_ni_packetizer;
  import ni_defines::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cur_addr;
  logic        msg_valid;
  logic        msg_ready;
  logic [3:0]  msg_dst;
  logic [11:0] msg_len;
  logic        pl_valid;
  logic        pl_ready;
  logic [28:0] pl_data;
  logic [31:0] data_out;
  logic        valid_out;
  logic        ready_in;
  logic        busy;
  logic        len_err;

  always #5 clk = ~clk;

  ni_packetizer dut (
    .clk      (clk),
    .rst      (rst),
    .cur_addr (cur_addr),
    .msg_valid(msg_valid),
    .msg_ready(msg_ready),
    .msg_dst  (msg_dst),
    .msg_len  (msg_len),
    .pl_valid (pl_valid),
    .pl_ready (pl_ready),
    .pl_data  (pl_data),
    .data_out (data_out),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .busy     (busy),
    .len_err  (len_err)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] sb[$];
  int          rem = 0;
  logic [8:0]  seq_m = '0;
  logic        err_pend = 1'b0;
  int          n_xfer = 0;
  int          n_body = 0;
  int          n_take = 0;
  logic        pl_take = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] seq_now(input logic [8:0] s);
`ifdef NI_PKT_SEQ_EN
    return s;
`else
    return 9'd0 & s;
`endif
  endfunction

  // reference model and scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      rem      = 0;
      seq_m    = '0;
      err_pend = 1'b0;
    end else begin
      check("len_err", 32'(len_err), 32'(err_pend));
      err_pend = 1'b0;
      if (msg_valid && msg_ready) begin
        if (msg_len == 12'd0 || msg_len == 12'd4095) begin
          err_pend = 1'b1;
        end else begin
          sb.push_back(make_header(msg_len, msg_dst, cur_addr,
                                   seq_now(seq_m)));
          rem   = int'(msg_len);
          seq_m = seq_m + 9'd1;
        end
      end
      if (pl_valid && pl_ready) begin
        sb.push_back({(rem == 1 ? FLIT_TAIL : FLIT_BODY), pl_data});
        rem     = rem - 1;
        n_take  = n_take + 1;
        pl_take = 1'b1;
      end
      if (valid_out && ready_in) begin
        n_xfer++;
        if (data_out[31:29] == FLIT_BODY) n_body++;
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) check("flit", data_out, sb.pop_front());
      end
    end
  end

  initial begin
    pl_data = 29'd1;
    forever begin
      @(posedge clk);
      #1;
      if (pl_take) begin
        pl_data = pl_data + 29'd1;
        pl_take = 1'b0;
      end
    end
  end

  task automatic send_msg(input logic [3:0] d, input logic [11:0] l);
    bit done;
    done = 0;
    @(posedge clk);
    #1;
    msg_valid = 1'b1;
    msg_dst   = d;
    msg_len   = l;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (msg_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    msg_valid = 1'b0;
    if (!done) check("msg_accept_timeout", 32'(msg_ready), 32'd1);
  endtask

  task automatic wait_idle(output int cyc);
    bit done;
    done = 0;
    cyc  = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      cyc++;
      if (!busy && !valid_out) done = 1;
    end
    if (!done) check("idle_timeout", 32'(busy), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pl_ready", 32'(pl_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int cyc;
  int base;

  initial begin
    rst       = 1'b0;
    cur_addr  = 4'h2;
    msg_valid = 1'b0;
    msg_dst   = 4'h0;
    msg_len   = 12'd0;
    pl_valid  = 1'b0;
    ready_in  = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_valid_out", 32'(valid_out), 32'd0);
    check("reset_data_out", data_out, 32'd0);
    check("reset_msg_ready", 32'(msg_ready), 32'd0);
    check("reset_pl_ready", 32'(pl_ready), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_len_err", 32'(len_err), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("msg_ready_hold", 32'(msg_ready), 32'd0);
    @(negedge clk);
    check("msg_ready_rise", 32'(msg_ready), 32'd1);

    // len 3, streaming payload
    pl_valid = 1'b1;
    n_xfer   = 0;
    n_body   = 0;
    send_msg(4'h9, 12'd3);
    @(negedge clk);
    check("hdr_value", data_out, 32'h2009_2400);
    check("hdr_valid", 32'(valid_out), 32'd1);
    check("busy_on", 32'(busy), 32'd1);
    wait_idle(cyc);
    check("burst_cycles", 32'(cyc), 32'd4);
    check("burst_flits", 32'(n_xfer), 32'd4);
    check("burst_bodies", 32'(n_body), 32'd2);

    // len 1: header then tail only
    n_xfer = 0;
    n_body = 0;
    send_msg(4'h5, 12'd1);
    wait_idle(cyc);
    check("len1_flits", 32'(n_xfer), 32'd2);
    check("len1_bodies", 32'(n_body), 32'd0);

    // header stalled for 5 cycles
    ready_in = 1'b0;
    send_msg(4'h3, 12'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_data", data_out,
            make_header(12'd2, 4'h3, 4'h2, seq_now(9'd2)));
      check("stall_valid", 32'(valid_out), 32'd1);
      check("stall_pl_ready", 32'(pl_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    ready_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("after_stall_id", 32'(data_out[31:29]), 32'(FLIT_BODY));
    wait_idle(cyc);

    // rejected lengths
    send_msg(4'h1, 12'd0);
    @(negedge clk);
    check("len0_valid", 32'(valid_out), 32'd0);
    check("len0_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    send_msg(4'h1, 12'd4095);
    @(negedge clk);
    check("len4095_valid", 32'(valid_out), 32'd0);
    check("len4095_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);

    // reset after two of five payload words
    pl_valid = 1'b0;
    send_msg(4'h7, 12'd5);
    @(posedge clk);
    #1;
    base     = n_take;
    pl_valid = 1'b1;
    for (int i = 0; i < 50 && n_take < base + 2; i++) @(negedge clk);
    check("mid_taken", 32'(n_take - base), 32'd2);
    @(posedge clk);
    #1;
    pl_valid = 1'b0;
    do_reset();
    pl_valid = 1'b1;
    n_xfer   = 0;
    send_msg(4'h7, 12'd1);
    @(negedge clk);
    check("fresh_hdr", data_out,
          make_header(12'd1, 4'h7, 4'h2, 9'd0));
    wait_idle(cyc);
    check("fresh_flits", 32'(n_xfer), 32'd2);

`ifdef NI_PKT_SEQ_EN
    do_reset();
    for (int m = 0; m < 513; m++) begin
      send_msg(4'h6, 12'd1);
      if (m == 511) begin
        @(negedge clk);
        check("seq_511", 32'(data_out[8:0]), 32'd511);
      end
    end
    @(negedge clk);
    check("seq_wrap", 32'(data_out[8:0]), 32'd0);
    wait_idle(cyc);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
